pattern_editor: RTL and testbench
=================================

Name: pattern_editor

Overview:
Consumes the registered cursor/edit codes from the USB keycode mapper and turns them into tracker pattern edits. Edge-detects and auto-repeats held key codes, maintains the row/channel cursor with wrap-around, and runs read-modify-write cycles on the pattern note RAM (1-cycle read latency). Its outputs drive the display highlight and the pattern RAM write port.

Parameters:
NUM_ROWS, 64, pattern rows; power of 2.
NUM_CHANNELS, 4, channels per row; power of 2.
NOTE_W, 8, width of one note cell.
NOTE_MAX, 96, highest legal note value; 0 means empty cell.
REPEAT_DELAY, 25000000, cycles a code must be held before the first auto-repeat.
REPEAT_RATE, 5000000, cycles between subsequent auto-repeats.

Ports:
clk  in  1  system clock.
Reset  in  1  synchronous, active-low reset (asserted when 0).
user_cursor  in  3  000 none, 001 left, 010 right, 011 up, 100 down; 101-111 treated as 000.
user_edit  in  2  00 none, 01 increment, 10 decrement, 11 delete.
cursor_row  out  log2(NUM_ROWS)  current row.
cursor_chan  out  log2(NUM_CHANNELS)  current channel.
mem_addr  out  log2(NUM_ROWS*NUM_CHANNELS)  RAM address = {row, chan}, latched at edit start.
mem_rd_en  out  1  RAM read strobe; data valid on mem_rdata the following cycle.
mem_rdata  in  NOTE_W  RAM read data.
mem_wr_en  out  1  RAM write strobe.
mem_wdata  out  NOTE_W  RAM write data.
busy  out  1  high while an edit is in progress.
edit_done  out  1  one-cycle pulse, coincident with mem_wr_en.

Behaviour:
- Reset (Reset==0 at a clk edge): cursor 0/0; mem_addr, mem_wdata 0; mem_rd_en, mem_wr_en, busy, edit_done 0; FSM IDLE; repeat counters and previous-code registers 0. A reset mid-edit aborts with no write.
- Triggering, independently for the cursor and edit channels: trigger when code != 0 and code != previous-cycle code (press or direct switch between codes). If the code is held unchanged, the first repeat trigger comes REPEAT_DELAY cycles after the press trigger, then one every REPEAT_RATE cycles. The counter clears whenever the code changes or returns to 0.
- Cursor: applied on the cycle after the trigger, in any FSM state. Left/right step chan by 1 and wrap (0 <-> NUM_CHANNELS-1); up/down step row by 1 and wrap (0 <-> NUM_ROWS-1). Row does not change on a channel wrap.
- Edit FSM: IDLE, RD, CAP, WR.
  - IDLE + inc/dec trigger: latch mem_addr = {row, chan} from the pre-move cursor, go to RD.
  - IDLE + delete trigger: latch mem_addr, set mem_wdata = 0, go to WR.
  - RD: mem_rd_en = 1, go to CAP.
  - CAP: compute mem_wdata from mem_rdata, go to WR.
  - WR: mem_wr_en = 1 and edit_done = 1, go to IDLE.
  - busy = 1 in RD, CAP and WR.
- Latency: inc/dec trigger at cycle T gives RD at T+1, CAP at T+2, WR at T+3. Delete trigger at T gives WR at T+1.
- Arithmetic:
  - inc: 0 -> 1; v < NOTE_MAX -> v+1; v >= NOTE_MAX -> NOTE_MAX (saturate).
  - dec: 0 stays 0; 1 -> 0; v > NOTE_MAX -> NOTE_MAX-1; otherwise v-1.
- Edit triggers arriving while busy are dropped, not queued; a held key is retried by auto-repeat.
- A cursor move and an edit triggering in the same cycle: the edit uses the pre-move cursor, and the move still applies.

Decomposition:
- Package tracker_pkg:
  - typedefs cursor_cmd_e (NONE, LEFT, RIGHT, UP, DOWN) and edit_cmd_e (NONE, INC, DEC, DEL) with the encodings above.
  - edit_state_e (IDLE, RD, CAP, WR).
  - default NUM_ROWS, NUM_CHANNELS, NOTE_MAX constants.
- Sub-module key_repeat, instanced twice: parameter W, REPEAT_DELAY, REPEAT_RATE; input code[W-1:0]; output trigger pulse. Contains the previous-code register and the repeat counter.

Test Plan:
- Reset with stale inputs: hold Reset=0 for 3 cycles while user_cursor=010 -> cursor 0/0, all strobes 0; after release, one right step (chan=1) on cycle +2.
- Wrap: cursor (0,0), pulse up once -> row=63, chan=0. Then pulse left once -> chan=3, row=63. Then pulse right -> chan=0.
- Inc RMW: cursor (2,1), mem_rdata=5, user_edit=01 for 1 cycle -> mem_rd_en at T+1 with mem_addr=9, mem_wr_en and edit_done at T+3 with mem_wdata=6, busy high for exactly 3 cycles.
- Saturation: mem_rdata=96 with inc -> wdata=96. mem_rdata=0 with dec -> wdata=0. Delete -> wr_en at T+1, wdata=0, no mem_rd_en.
- Auto-repeat: with REPEAT_DELAY=10, REPEAT_RATE=4, hold down for 30 cycles -> triggers at 0, 10, 14, 18, 22, 26 (row advances 6); release and re-press -> immediate trigger.
- Busy drop: issue inc, then switch to dec during RD -> dec dropped, single write. Reset=0 during CAP -> no mem_wr_en, FSM IDLE.

Source files
------------

// File: rtl/tracker_pkg.sv
// +---------------------------------------------------------------------------+
// | tracker_pkg                                                               |
// | Shared command encodings, edit FSM states and default geometry.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package tracker_pkg;

  localparam int c_num_rows     = 64;
  localparam int c_num_channels = 4;
  localparam int c_note_max     = 96;

  typedef enum logic [2:0] {
    CUR_NONE  = 3'b000,
    CUR_LEFT  = 3'b001,
    CUR_RIGHT = 3'b010,
    CUR_UP    = 3'b011,
    CUR_DOWN  = 3'b100
  } cursor_cmd_e;

  typedef enum logic [1:0] {
    EDIT_NONE = 2'b00,
    EDIT_INC  = 2'b01,
    EDIT_DEC  = 2'b10,
    EDIT_DEL  = 2'b11
  } edit_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } edit_state_e;

endpackage

`default_nettype wire

// File: rtl/key_repeat.sv
// +---------------------------------------------------------------------------+
// | key_repeat                                                                |
// | Press edge-detect plus auto-repeat for a held key code; registered pulse. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module key_repeat #(
  parameter int W            = 3,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [W-1:0] code,
  output logic         trigger,
  output logic [W-1:0] code_q
);

  localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);

  logic [W-1:0]       r_prev;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_rep;
  logic               r_trig;

  // r_prev doubles as the code that caused the current trigger pulse.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_prev <= '0;
      r_cnt  <= '0;
      r_rep  <= 1'b0;
      r_trig <= 1'b0;
    end else begin
      r_prev <= code;
      r_trig <= 1'b0;
      if (code == '0 || code != r_prev) begin
        r_cnt  <= '0;
        r_rep  <= 1'b0;
        r_trig <= (code != '0);
      end else if (r_cnt == (r_rep ? c_rate_last : c_delay_last)) begin
        r_cnt  <= '0;
        r_rep  <= 1'b1;
        r_trig <= 1'b1;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign trigger = r_trig;
  assign code_q  = r_prev;

endmodule

`default_nettype wire

// File: rtl/pattern_editor.sv
// +---------------------------------------------------------------------------+
// | pattern_editor                                                            |
// | Cursor movement with wrap and read-modify-write note edits on pattern RAM.|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module pattern_editor
  import tracker_pkg::*;
#(
  parameter int NUM_ROWS     = c_num_rows,
  parameter int NUM_CHANNELS = c_num_channels,
  parameter int NOTE_W       = 8,
  parameter int NOTE_MAX     = c_note_max,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                                      clk,
  input  logic                                      Reset,
  input  logic [2:0]                                user_cursor,
  input  logic [1:0]                                user_edit,
  output logic [$clog2(NUM_ROWS)-1:0]               cursor_row,
  output logic [$clog2(NUM_CHANNELS)-1:0]           cursor_chan,
  output logic [$clog2(NUM_ROWS*NUM_CHANNELS)-1:0]  mem_addr,
  output logic                                      mem_rd_en,
  input  logic [NOTE_W-1:0]                         mem_rdata,
  output logic                                      mem_wr_en,
  output logic [NOTE_W-1:0]                         mem_wdata,
  output logic                                      busy,
  output logic                                      edit_done
);

  localparam int c_row_w  = $clog2(NUM_ROWS);
  localparam int c_chan_w = $clog2(NUM_CHANNELS);
  localparam int c_addr_w = $clog2(NUM_ROWS*NUM_CHANNELS);
  localparam logic [NOTE_W-1:0] c_note_max_v = NOTE_W'(NOTE_MAX);

  logic [2:0]          w_cur_code;
  logic                w_cur_trig;
  logic [2:0]          w_cur_q;
  logic                w_edit_trig;
  logic [1:0]          w_edit_q;
  cursor_cmd_e         w_cur_cmd;
  edit_cmd_e           w_edit_cmd;

  logic [c_row_w-1:0]  r_row;
  logic [c_chan_w-1:0] r_chan;

  edit_state_e         r_state, w_state_nxt;
  logic [c_addr_w-1:0] r_addr, w_addr_nxt;
  logic [NOTE_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_dec, w_dec_nxt;
  logic [NOTE_W-1:0]   w_note_inc, w_note_dec;

  // Undefined cursor codes never reach the repeat logic.
  assign w_cur_code = (user_cursor > 3'd4) ? 3'd0 : user_cursor;

  key_repeat #(
    .W            (3),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_cur_rep (
    .clk     (clk),
    .Reset   (Reset),
    .code    (w_cur_code),
    .trigger (w_cur_trig),
    .code_q  (w_cur_q)
  );

  key_repeat #(
    .W            (2),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_edit_rep (
    .clk     (clk),
    .Reset   (Reset),
    .code    (user_edit),
    .trigger (w_edit_trig),
    .code_q  (w_edit_q)
  );

  assign w_cur_cmd  = cursor_cmd_e'(w_cur_q);
  assign w_edit_cmd = edit_cmd_e'(w_edit_q);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_row  <= '0;
      r_chan <= '0;
    end else if (w_cur_trig) begin
      unique case (w_cur_cmd)
        CUR_LEFT:  r_chan <= r_chan - c_chan_w'(1);
        CUR_RIGHT: r_chan <= r_chan + c_chan_w'(1);
        CUR_UP:    r_row  <= r_row - c_row_w'(1);
        CUR_DOWN:  r_row  <= r_row + c_row_w'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_note_inc = (mem_rdata >= c_note_max_v) ? c_note_max_v : mem_rdata + NOTE_W'(1);
    if (mem_rdata == '0)
      w_note_dec = '0;
    else if (mem_rdata > c_note_max_v)
      w_note_dec = c_note_max_v - NOTE_W'(1);
    else
      w_note_dec = mem_rdata - NOTE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  // Edit triggers outside IDLE are simply ignored; auto-repeat retries them.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_dec_nxt   = r_dec;
    unique case (r_state)
      IDLE: begin
        if (w_edit_trig) begin
          w_addr_nxt = {r_row, r_chan};
          if (w_edit_cmd == EDIT_DEL) begin
            w_wdata_nxt = '0;
            w_state_nxt = WR;
          end else begin
            w_dec_nxt   = (w_edit_cmd == EDIT_DEC);
            w_state_nxt = RD;
          end
        end
      end
      RD:  w_state_nxt = CAP;
      CAP: begin
        w_wdata_nxt = r_dec ? w_note_dec : w_note_inc;
        w_state_nxt = WR;
      end
      WR:  w_state_nxt = IDLE;
    endcase
  end

  assign cursor_row  = r_row;
  assign cursor_chan = r_chan;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_rd_en   = (r_state == RD);
  assign mem_wr_en   = (r_state == WR);
  assign edit_done   = (r_state == WR);
  assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pattern_editor.sv
// +---------------------------------------------------------------------------+
// | tb_pattern_editor                                                         |
// | Directed self-checking bench for pattern_editor.                          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_pattern_editor;

  logic       clk = 1'b0;
  logic       Reset;
  logic [2:0] user_cursor;
  logic [1:0] user_edit;
  logic [5:0] cursor_row;
  logic [1:0] cursor_chan;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       edit_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_editor #(
    .NUM_ROWS     (64),
    .NUM_CHANNELS (4),
    .NOTE_W       (8),
    .NOTE_MAX     (96),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .user_cursor (user_cursor),
    .user_edit   (user_edit),
    .cursor_row  (cursor_row),
    .cursor_chan (cursor_chan),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .edit_done   (edit_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_cursor(input logic [2:0] c);
    user_cursor = c;
    tick();
    user_cursor = 3'd0;
    tick();
  endtask

  // One-cycle inc/dec press; checks the read at T+1 and the write at T+3.
  task automatic rmw(input logic [1:0] code, input logic [7:0] rd, input logic [7:0] exp,
                     input logic [7:0] exp_addr, input string tag);
    mem_rdata = rd;
    user_edit = code;
    tick();
    user_edit = 2'd0;
    check({tag, "_busy_T"}, busy, 0);
    tick();
    check({tag, "_rd_en"}, mem_rd_en, 1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    tick();
    check({tag, "_cap_busy"}, busy, 1);
    check({tag, "_cap_rd"}, mem_rd_en, 0);
    tick();
    check({tag, "_wr_en"}, mem_wr_en, 1);
    check({tag, "_done"}, edit_done, 1);
    check({tag, "_wdata"}, mem_wdata, exp);
    tick();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_wr_off"}, mem_wr_en, 0);
  endtask

  initial begin
    logic [5:0] exp_row;
    int         wr_count;

    Reset       = 1'b0;
    user_cursor = 3'b010;
    user_edit   = 2'd0;
    mem_rdata   = 8'd0;

    // Reset with a stale right code held
    tick(); tick(); tick();
    check("rst_row", cursor_row, 0);
    check("rst_chan", cursor_chan, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rd", mem_rd_en, 0);
    check("rst_wr", mem_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", edit_done, 0);
    Reset = 1'b1;
    tick();
    check("rel_chan_c1", cursor_chan, 0);
    user_cursor = 3'd0;
    tick();
    check("rel_chan_c2", cursor_chan, 1);
    tick();
    check("rel_chan_hold", cursor_chan, 1);

    // Wrap-around
    pulse_cursor(3'b001);
    check("left_to0", cursor_chan, 0);
    pulse_cursor(3'b011);
    check("up_wrap_row", cursor_row, 63);
    check("up_wrap_chan", cursor_chan, 0);
    pulse_cursor(3'b001);
    check("left_wrap_chan", cursor_chan, 3);
    check("left_wrap_row", cursor_row, 63);
    pulse_cursor(3'b010);
    check("right_wrap_chan", cursor_chan, 0);
    check("right_wrap_row", cursor_row, 63);
    pulse_cursor(3'b111);
    check("bad_code_row", cursor_row, 63);
    check("bad_code_chan", cursor_chan, 0);

    // Move to (2,1)
    pulse_cursor(3'b100);
    pulse_cursor(3'b100);
    pulse_cursor(3'b100);
    pulse_cursor(3'b010);
    check("pos_row", cursor_row, 2);
    check("pos_chan", cursor_chan, 1);

    // Read-modify-write edits at address {2,1} = 9
    rmw(2'b01, 8'd5,   8'd6,  8'd9, "inc5");
    rmw(2'b01, 8'd96,  8'd96, 8'd9, "inc_sat");
    rmw(2'b10, 8'd0,   8'd0,  8'd9, "dec0");
    rmw(2'b10, 8'd1,   8'd0,  8'd9, "dec1");
    rmw(2'b10, 8'd100, 8'd95, 8'd9, "dec_over");
    rmw(2'b01, 8'd0,   8'd1,  8'd9, "inc0");

    // Delete: straight to write, no read
    mem_rdata = 8'd77;
    user_edit = 2'b11;
    tick();
    user_edit = 2'd0;
    check("del_no_rd_T", mem_rd_en, 0);
    tick();
    check("del_wr", mem_wr_en, 1);
    check("del_done", edit_done, 1);
    check("del_wdata", mem_wdata, 0);
    check("del_no_rd", mem_rd_en, 0);
    tick();
    check("del_idle", busy, 0);

    // Auto-repeat on held down key: row steps at ticks 2,12,16,20,24,28
    exp_row = cursor_row;
    user_cursor = 3'b100;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 2 || n == 12 || n == 16 || n == 20 || n == 24 || n == 28)
        exp_row = exp_row + 6'd1;
      check("repeat_row", cursor_row, exp_row);
    end
    user_cursor = 3'd0;
    tick(); tick();
    check("repeat_total", cursor_row, 8);
    user_cursor = 3'b100;
    tick(); tick();
    check("repress_row", cursor_row, 9);
    user_cursor = 3'd0;
    tick();

    // Edit trigger during busy is dropped
    mem_rdata = 8'd10;
    wr_count  = 0;
    user_edit = 2'b01;
    tick();
    user_edit = 2'b10;
    tick();
    user_edit = 2'd0;
    tick();
    tick();
    check("drop_wdata", mem_wdata, 11);
    for (int i = 0; i < 16; i++) begin
      if (mem_wr_en) wr_count++;
      tick();
    end
    check("drop_single_wr", wr_count, 1);

    // Reset during CAP aborts the write
    user_edit = 2'b01;
    tick();
    user_edit = 2'd0;
    tick();
    check("abort_rd", mem_rd_en, 1);
    tick();
    Reset = 1'b0;
    tick();
    check("abort_wr", mem_wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_row", cursor_row, 0);
    Reset = 1'b1;
    wr_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_wr_en) wr_count++;
      tick();
    end
    check("abort_no_wr", wr_count, 0);

    // Simultaneous move and delete: edit uses pre-move cursor
    user_cursor = 3'b010;
    user_edit   = 2'b11;
    tick();
    user_cursor = 3'd0;
    user_edit   = 2'd0;
    tick();
    check("simul_wr", mem_wr_en, 1);
    check("simul_addr", mem_addr, 0);
    check("simul_chan", cursor_chan, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
